// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registered ALU op decode with illegal-encoding detection and RV32M mul/div sequencing.
// Mul/div sequencing is compiled in only when ALU_CTRL_SEQ_RV32M_EN is defined.
module alu_ctrl_seq #(
   parameter int MUL_LAT      = 4,
   parameter int DIV_LAT      = 33,
   parameter int CNT_W        = 6,
   parameter bit SHIFT_STRICT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dec_valid,
   input  logic [1:0] ALU_Op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       flush,
   output logic [3:0] op,
   output logic       op_valid,
   output logic       illegal,
   output logic       md_start,
   output logic [2:0] md_func,
   output logic       md_is_div,
   output logic       stall,
   output logic       md_done
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_SLT  = 4'b1100;
   localparam logic [3:0] OP_SLTU = 4'b1101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   // Counter reload values: MD_RUN lasts LAT cycles, counting LAT-1 down to 0
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept_p0;
   logic [3:0]       op_p0;
   logic             ill_p0;
   logic             md_p0;
   logic [3:0]       op_p1;
   logic             vld_p1;
   logic             ill_p1;

   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'd0:    base_op = OP_ADD;
         3'd1:    base_op = OP_SLL;
         3'd2:    base_op = OP_SLT;
         3'd3:    base_op = OP_SLTU;
         3'd4:    base_op = OP_XOR;
         3'd5:    base_op = OP_SRL;
         3'd6:    base_op = OP_OR;
         default: base_op = OP_AND;
      endcase
   endfunction

   // Stage p0: combinational decode of the instruction in the decode slot
   always_comb begin
      op_p0  = OP_ADD;
      ill_p0 = 1'b0;
      md_p0  = 1'b0;
      case (ALU_Op)
         2'b00: op_p0 = OP_ADD;
         2'b01: op_p0 = OP_SUB;
         2'b10: begin
            if (funct7 == F7_BASE) begin
               op_p0 = base_op(funct3);
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'd0)      op_p0  = OP_SUB;
               else if (funct3 == 3'd5) op_p0  = OP_SRA;
               else                     ill_p0 = 1'b1;
            end else if (funct7 == F7_MD) begin
`ifdef ALU_CTRL_SEQ_RV32M_EN
               md_p0 = 1'b1;
`else
               ill_p0 = 1'b1;
`endif
            end else begin
               ill_p0 = 1'b1;
            end
         end
         default: begin
            // I-type: funct7 is immediate except for shift encodings
            op_p0 = base_op(funct3);
            if (funct3 == 3'd1 && SHIFT_STRICT && funct7 != F7_BASE)
               ill_p0 = 1'b1;
            if (funct3 == 3'd5) begin
               op_p0 = funct7[5] ? OP_SRA : OP_SRL;
               if (SHIFT_STRICT && funct7 != F7_BASE && funct7 != F7_ALT)
                  ill_p0 = 1'b1;
            end
         end
      endcase
      if (ill_p0) op_p0 = OP_ADD;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept_p0 = 1'b0;
      case (state)
         IDLE, MD_DONE: begin
            state_nxt = IDLE;
            accept_p0 = dec_valid;
            if (dec_valid && md_p0) begin
               state_nxt = MD_RUN;
               cnt_nxt   = funct3[2] ? DIV_CNT : MUL_CNT;
            end
         end
         MD_RUN: begin
            if (cnt == '0) state_nxt = MD_DONE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         accept_p0 = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Stage p1: registered outputs toward EX
   always_ff @(posedge clk) begin
      if (rst) begin
         op_p1  <= OP_AND;
         vld_p1 <= 1'b0;
         ill_p1 <= 1'b0;
      end else begin
         vld_p1 <= accept_p0 && !ill_p0 && !md_p0;
         ill_p1 <= accept_p0 && ill_p0;
         if (accept_p0 && !md_p0) op_p1 <= op_p0;
      end
   end

   assign op       = op_p1;
   assign op_valid = vld_p1;
   assign illegal  = ill_p1;

`ifdef ALU_CTRL_SEQ_RV32M_EN
   logic       start_p1;
   logic [2:0] md_func_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         start_p1   <= 1'b0;
         md_func_p1 <= 3'b000;
      end else begin
         start_p1 <= accept_p0 && md_p0;
         if (accept_p0 && md_p0) md_func_p1 <= funct3;
      end
   end

   assign md_start  = start_p1;
   assign md_func   = md_func_p1;
   assign md_is_div = md_func_p1[2];
   assign stall     = (state == MD_RUN);
   assign md_done   = (state == MD_DONE);
`else
   assign md_start  = 1'b0;
   assign md_func   = 3'b000;
   assign md_is_div = 1'b0;
   assign stall     = 1'b0;
   assign md_done   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode vector table, reset/flush/hold checks, and
// mul/div sequencing when ALU_CTRL_SEQ_RV32M_EN is defined.
module tb_alu_ctrl_seq;

   logic       clk;
   logic       rst;
   logic       dec_valid;
   logic [1:0] ALU_Op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       flush;

   logic [3:0] op, ns_op;
   logic       op_valid, ns_op_valid;
   logic       illegal, ns_illegal;
   logic       md_start, ns_md_start;
   logic [2:0] md_func, ns_md_func;
   logic       md_is_div, ns_md_is_div;
   logic       stall, ns_stall;
   logic       md_done, ns_md_done;

   int checks;
   int failures;

   alu_ctrl_seq #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6), .SHIFT_STRICT(1'b1)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .ALU_Op(ALU_Op),
      .funct3(funct3), .funct7(funct7), .flush(flush),
      .op(op), .op_valid(op_valid), .illegal(illegal), .md_start(md_start),
      .md_func(md_func), .md_is_div(md_is_div), .stall(stall), .md_done(md_done)
   );

   alu_ctrl_seq #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6), .SHIFT_STRICT(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .ALU_Op(ALU_Op),
      .funct3(funct3), .funct7(funct7), .flush(flush),
      .op(ns_op), .op_valid(ns_op_valid), .illegal(ns_illegal), .md_start(ns_md_start),
      .md_func(ns_md_func), .md_is_div(ns_md_is_div), .stall(ns_stall), .md_done(ns_md_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] aop;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] e_op;
      logic       e_vld;
      logic       e_ill;
      logic [3:0] n_op;
      logic       n_vld;
      logic       n_ill;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
      dec_valid = v;
      ALU_Op    = a;
      funct3    = f3;
      funct7    = f7;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      flush    = 1'b0;
      rst      = 1'b1;
      drive(1'b1, 2'b01, 3'd0, 7'h00);

      vecs[0]  = '{2'b00, 3'd3, 7'h7f, 4'b0010, 1, 0, 4'b0010, 1, 0};
      vecs[1]  = '{2'b01, 3'd0, 7'h00, 4'b0110, 1, 0, 4'b0110, 1, 0};
      vecs[2]  = '{2'b10, 3'd0, 7'h00, 4'b0010, 1, 0, 4'b0010, 1, 0};
      vecs[3]  = '{2'b10, 3'd1, 7'h00, 4'b1010, 1, 0, 4'b1010, 1, 0};
      vecs[4]  = '{2'b10, 3'd2, 7'h00, 4'b1100, 1, 0, 4'b1100, 1, 0};
      vecs[5]  = '{2'b10, 3'd3, 7'h00, 4'b1101, 1, 0, 4'b1101, 1, 0};
      vecs[6]  = '{2'b10, 3'd4, 7'h00, 4'b0101, 1, 0, 4'b0101, 1, 0};
      vecs[7]  = '{2'b10, 3'd5, 7'h00, 4'b1000, 1, 0, 4'b1000, 1, 0};
      vecs[8]  = '{2'b10, 3'd6, 7'h00, 4'b0001, 1, 0, 4'b0001, 1, 0};
      vecs[9]  = '{2'b10, 3'd7, 7'h00, 4'b0000, 1, 0, 4'b0000, 1, 0};
      vecs[10] = '{2'b10, 3'd0, 7'h20, 4'b0110, 1, 0, 4'b0110, 1, 0};
      vecs[11] = '{2'b10, 3'd5, 7'h20, 4'b1001, 1, 0, 4'b1001, 1, 0};
      vecs[12] = '{2'b10, 3'd7, 7'h20, 4'b0010, 0, 1, 4'b0010, 0, 1};
      vecs[13] = '{2'b10, 3'd2, 7'h10, 4'b0010, 0, 1, 4'b0010, 0, 1};
      vecs[14] = '{2'b11, 3'd0, 7'h20, 4'b0010, 1, 0, 4'b0010, 1, 0};
      vecs[15] = '{2'b11, 3'd7, 7'h7f, 4'b0000, 1, 0, 4'b0000, 1, 0};
      vecs[16] = '{2'b11, 3'd5, 7'h20, 4'b1001, 1, 0, 4'b1001, 1, 0};
      vecs[17] = '{2'b11, 3'd5, 7'h00, 4'b1000, 1, 0, 4'b1000, 1, 0};
      vecs[18] = '{2'b11, 3'd1, 7'h20, 4'b0010, 0, 1, 4'b1010, 1, 0};
      vecs[19] = '{2'b11, 3'd5, 7'h60, 4'b0010, 0, 1, 4'b1001, 1, 0};
      vecs[20] = '{2'b11, 3'd4, 7'h55, 4'b0101, 1, 0, 4'b0101, 1, 0};

      // Reset held two cycles with a valid instruction present
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_op", op, 4'b0000);
         chk("rst_op_valid", op_valid, 1'b0);
         chk("rst_illegal", illegal, 1'b0);
         chk("rst_md_start", md_start, 1'b0);
         chk("rst_md_done", md_done, 1'b0);
         chk("rst_stall", stall, 1'b0);
         chk("rst_md_func", md_func, 3'b000);
         chk("rst_md_is_div", md_is_div, 1'b0);
      end
      rst = 1'b0;
      step();
      chk("post_rst_op", op, 4'b0110);
      chk("post_rst_op_valid", op_valid, 1'b1);

      // Decode table, one vector accepted per cycle
      for (int i = 0; i < 21; i++) begin
         drive(1'b1, vecs[i].aop, vecs[i].f3, vecs[i].f7);
         step();
         chk($sformatf("vec%0d_op", i), op, vecs[i].e_op);
         chk($sformatf("vec%0d_vld", i), op_valid, vecs[i].e_vld);
         chk($sformatf("vec%0d_ill", i), illegal, vecs[i].e_ill);
         chk($sformatf("vec%0d_ns_op", i), ns_op, vecs[i].n_op);
         chk($sformatf("vec%0d_ns_vld", i), ns_op_valid, vecs[i].n_vld);
         chk($sformatf("vec%0d_ns_ill", i), ns_illegal, vecs[i].n_ill);
         chk($sformatf("vec%0d_stall", i), stall, 1'b0);
      end

      // No acceptance: op holds XOR from the last vector, pulses clear
      drive(1'b0, 2'b01, 3'd0, 7'h00);
      step();
      chk("hold_op", op, 4'b0101);
      chk("hold_vld", op_valid, 1'b0);
      step();
      chk("hold_op2", op, 4'b0101);

      // Illegal followed by a no-accept cycle: illegal is a single pulse
      drive(1'b1, 2'b10, 3'd3, 7'h20);
      step();
      chk("ill_pulse", illegal, 1'b1);
      chk("ill_op", op, 4'b0010);
      drive(1'b0, 2'b10, 3'd3, 7'h20);
      step();
      chk("ill_pulse_end", illegal, 1'b0);

      // Flush drops a simultaneous instruction; op holds
      drive(1'b1, 2'b10, 3'd4, 7'h00);
      step();
      chk("pre_flush_op", op, 4'b0101);
      drive(1'b1, 2'b01, 3'd0, 7'h00);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_drop_vld", op_valid, 1'b0);
      chk("flush_hold_op", op, 4'b0101);

`ifdef ALU_CTRL_SEQ_RV32M_EN
      // MUL, latency 4: accepted at E0
      drive(1'b1, 2'b10, 3'd0, 7'h01);
      step();
      drive(1'b0, 2'b00, 3'd0, 7'h00);
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("mul_c%0d_start", k), md_start, (k == 1));
         chk($sformatf("mul_c%0d_stall", k), stall, (k <= 4));
         chk($sformatf("mul_c%0d_done", k), md_done, (k == 5));
         chk($sformatf("mul_c%0d_vld", k), op_valid, 1'b0);
         if (k < 5) step();
      end
      chk("mul_is_div", md_is_div, 1'b0);
      chk("mul_func", md_func, 3'b000);
      step();
      chk("mul_idle_done", md_done, 1'b0);

      // DIV, latency 33, with dec_valid held high through the stall
      drive(1'b1, 2'b10, 3'd4, 7'h01);
      step();
      drive(1'b1, 2'b00, 3'd0, 7'h00);
      chk("div_start", md_start, 1'b1);
      chk("div_func", md_func, 3'b100);
      chk("div_is_div", md_is_div, 1'b1);
      for (int k = 1; k <= 34; k++) begin
         chk($sformatf("div_c%0d_stall", k), stall, (k <= 33));
         chk($sformatf("div_c%0d_done", k), md_done, (k == 34));
         chk($sformatf("div_c%0d_vld", k), op_valid, 1'b0);
         if (k == 34) drive(1'b1, 2'b10, 3'd0, 7'h01);
         step();
      end
      drive(1'b0, 2'b00, 3'd0, 7'h00);
      chk("b2b_start", md_start, 1'b1);
      chk("b2b_func", md_func, 3'b000);
      chk("b2b_is_div", md_is_div, 1'b0);
      chk("b2b_stall", stall, 1'b1);
      for (int k = 0; k < 4; k++) step();
      chk("b2b_done", md_done, 1'b1);
      step();

      // Flush at the 10th MD_RUN cycle of a divide
      drive(1'b1, 2'b10, 3'd5, 7'h01);
      step();
      drive(1'b0, 2'b00, 3'd0, 7'h00);
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("fdiv_c%0d_stall", k), stall, 1'b1);
         if (k < 10) step();
      end
      flush = 1'b1;
      drive(1'b1, 2'b01, 3'd0, 7'h00);
      step();
      flush = 1'b0;
      chk("fdiv_stall", stall, 1'b0);
      chk("fdiv_done", md_done, 1'b0);
      chk("fdiv_vld", op_valid, 1'b0);
      chk("fdiv_func_hold", md_func, 3'b101);
      drive(1'b1, 2'b00, 3'd0, 7'h00);
      step();
      drive(1'b0, 2'b00, 3'd0, 7'h00);
      chk("fdiv_next_op", op, 4'b0010);
      chk("fdiv_next_vld", op_valid, 1'b1);
      begin
         logic seen_done;
         seen_done = 1'b0;
         for (int k = 0; k < 30; k++) begin
            step();
            if (md_done || stall) seen_done = 1'b1;
         end
         chk("fdiv_no_done", seen_done, 1'b0);
      end
`else
      // Without RV32M the mul/div encoding is illegal and no sequencing occurs
      drive(1'b1, 2'b10, 3'd4, 7'h01);
      step();
      drive(1'b0, 2'b00, 3'd0, 7'h00);
      chk("nomd_ill", illegal, 1'b1);
      chk("nomd_vld", op_valid, 1'b0);
      chk("nomd_op", op, 4'b0010);
      chk("nomd_start", md_start, 1'b0);
      chk("nomd_stall", stall, 1'b0);
      chk("nomd_func", md_func, 3'b000);
      drive(1'b1, 2'b01, 3'd0, 7'h00);
      step();
      drive(1'b0, 2'b00, 3'd0, 7'h00);
      chk("nomd_next_op", op, 4'b0110);
      chk("nomd_next_vld", op_valid, 1'b1);
      chk("nomd_done", md_done, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
